hlm_readout_controller: RTL and testbench

- Read-side counterpart to the address-counter/block-memory-storage write path.
- Accepts SSID read requests and walks that SSID's hit-list rows in the block memory storage, one row per read transaction.
- Streams every stored hit word downstream with valid/ready backpressure.
- Signals per-SSID completion with a hit count; flags a sticky error if storage never answers a read.

---
 rtl/hlm_readout_controller.sv | 164 ++++++++++++++++
 tb/tb_hlm_readout_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlm_readout_controller.sv
// hlm_readout_controller: walks one SSID's hit list in block memory storage
// and streams hit words downstream. Optional stats via HLM_READOUT_STATS_EN.
module hlm_readout_controller #(
    parameter int SSIDBITS    = 16,
    parameter int NCOLS_HLM   = 32,
    parameter int INDEXBITS   = 4,
    parameter int MAXHITS     = 16,
    parameter int READTIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reqValid,
    input  logic [SSIDBITS-1:0]  reqSSID,
    output logic                 reqReady,
    output logic                 memRead,
    output logic [SSIDBITS-1:0]  memSSID,
    output logic [INDEXBITS-1:0] memIndex,
    input  logic                 memReadReady,
    input  logic                 memHitValid,
    input  logic [NCOLS_HLM-1:0] memHitInfo,
    output logic                 outValid,
    output logic [SSIDBITS-1:0]  outSSID,
    output logic [NCOLS_HLM-1:0] outHitInfo,
    input  logic                 outReady,
    output logic                 ssidDone,
    output logic [INDEXBITS:0]   ssidHitCount,
    output logic                 readError
`ifdef HLM_READOUT_STATS_EN
    ,
    output logic [31:0]          totalHits
`endif
);

    localparam int CNTBITS   = INDEXBITS + 1;
    localparam int TIMERBITS = $clog2(READTIMEOUT + 1);
    localparam logic [TIMERBITS-1:0] TIMERLAST = TIMERBITS'(READTIMEOUT - 1);
    localparam logic [CNTBITS-1:0]   IDXLAST   = CNTBITS'(MAXHITS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } stateType;

    stateType              state;
    stateType              nextState;
    logic [SSIDBITS-1:0]   ssidReg;
    logic [CNTBITS-1:0]    idx;
    logic [CNTBITS-1:0]    idxNext;
    logic [TIMERBITS-1:0]  timer;
    logic [NCOLS_HLM-1:0]  hitReg;
    logic                  timerExpired;

    assign idxNext      = idx + 1'b1;
    assign timerExpired = (timer == TIMERLAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a storage reply beats a simultaneous timeout
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = WAIT;
            end
            WAIT: begin
                if (memReadReady) begin
                    nextState = memHitValid ? EMIT : DONE;
                end else if (timerExpired) begin
                    nextState = DONE;
                end
            end
            EMIT: begin
                if (outReady) begin
                    nextState = (idxNext == IDXLAST) ? DONE : ISSUE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath registers: latched SSID, row index, timer, hit word, error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ssidReg   <= '0;
            idx       <= '0;
            timer     <= '0;
            hitReg    <= '0;
            readError <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        ssidReg <= reqSSID;
                        idx     <= '0;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (memReadReady && memHitValid) begin
                        hitReg <= memHitInfo;
                    end else if (!memReadReady && timerExpired) begin
                        readError <= 1'b1;
                    end
                end
                EMIT: begin
                    if (outReady) begin
                        idx <= idxNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign reqReady     = (state == IDLE);
    assign memRead      = (state == ISSUE);
    assign memSSID      = ssidReg;
    assign memIndex     = idx[INDEXBITS-1:0];
    assign outValid     = (state == EMIT);
    assign outSSID      = ssidReg;
    assign outHitInfo   = hitReg;
    assign ssidDone     = (state == DONE);
    assign ssidHitCount = (state == DONE) ? idx : '0;

`ifdef HLM_READOUT_STATS_EN
    logic [31:0] hitTotal;

    // Saturating count of hit words accepted downstream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hitTotal <= '0;
        end else if (outValid && outReady && (hitTotal != 32'hFFFF_FFFF)) begin
            hitTotal <= hitTotal + 32'd1;
        end
    end

    assign totalHits = hitTotal;
`endif

endmodule

// File: tb/tb_hlm_readout_controller.sv
// tb_hlm_readout_controller: scoreboard bench with a behavioural storage
// model, random requests, backpressure, timeout and reset scenarios.
module tb_hlm_readout_controller;

    localparam int SSIDBITS  = 16;
    localparam int NCOLS     = 32;
    localparam int INDEXBITS = 4;
    localparam int MAXHITS   = 16;
    localparam int TIMEOUT   = 64;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 reqValid;
    logic [SSIDBITS-1:0]  reqSSID;
    logic                 reqReady;
    logic                 memRead;
    logic [SSIDBITS-1:0]  memSSID;
    logic [INDEXBITS-1:0] memIndex;
    logic                 memReadReady;
    logic                 memHitValid;
    logic [NCOLS-1:0]     memHitInfo;
    logic                 outValid;
    logic [SSIDBITS-1:0]  outSSID;
    logic [NCOLS-1:0]     outHitInfo;
    logic                 outReady;
    logic                 ssidDone;
    logic [INDEXBITS:0]   ssidHitCount;
    logic                 readError;
`ifdef HLM_READOUT_STATS_EN
    logic [31:0]          totalHits;
`endif

    hlm_readout_controller dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqSSID      (reqSSID),
        .reqReady     (reqReady),
        .memRead      (memRead),
        .memSSID      (memSSID),
        .memIndex     (memIndex),
        .memReadReady (memReadReady),
        .memHitValid  (memHitValid),
        .memHitInfo   (memHitInfo),
        .outValid     (outValid),
        .outSSID      (outSSID),
        .outHitInfo   (outHitInfo),
        .outReady     (outReady),
        .ssidDone     (ssidDone),
        .ssidHitCount (ssidHitCount),
        .readError    (readError)
`ifdef HLM_READOUT_STATS_EN
        ,
        .totalHits    (totalHits)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want nothing", name, act);
    endtask

    // Storage contents: length per SSID, word derived from SSID and row
    int lenOf [int];
    int latency = 1;

    function automatic logic [NCOLS-1:0] hitWord(input int s, input int i);
        return 32'(s * 40503) ^ 32'(i * 16843009) ^ 32'hA500_00C3;
    endfunction

    // Scoreboard queues
    logic [19:0] readQ [$];
    logic [47:0] hitQ [$];
    int          doneQ [$];
    int          doneSeen = 0;
    int          acceptCnt = 0;
    logic        expErr = 1'b0;

    // Storage responder: one reply 'latency' cycles after memRead; 0 = silent
    initial begin
        memReadReady = 1'b0;
        memHitValid  = 1'b0;
        memHitInfo   = '0;
        forever begin
            @(negedge clock);
            if (!reset && memRead && latency > 0) begin
                int s;
                int i;
                int n;
                s = int'(memSSID);
                i = int'(memIndex);
                n = latency;
                repeat (n) @(posedge clock);
                #1;
                memReadReady = 1'b1;
                memHitValid  = (i < lenOf[s]);
                memHitInfo   = memHitValid ? hitWord(s, i) : NCOLS'($urandom);
                @(posedge clock);
                #1;
                memReadReady = 1'b0;
                memHitValid  = 1'b0;
                memHitInfo   = '0;
            end
        end
    end

    // Downstream ready driver
    bit bpRandom = 1'b0;
    bit bpHold = 1'b0;

    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (bpHold) outReady = 1'b0;
            else if (bpRandom) outReady = ($urandom_range(0, 2) != 0);
            else outReady = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents something
    logic        prevHold = 1'b0;
    logic [47:0] prevOut = '0;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prevHold = 1'b0;
                continue;
            end
            if (prevHold) begin
                chk("holdValid", outValid, 1);
                chk("holdData", {outSSID, outHitInfo}, prevOut);
                chk("holdNoRead", memRead, 0);
            end
            if (memRead) begin
                if (readQ.size() == 0) failNow("readUnexpected", {memSSID, memIndex});
                else chk("readAddr", {memSSID, memIndex}, readQ.pop_front());
            end
            if (outValid && outReady) begin
                acceptCnt++;
                if (hitQ.size() == 0) failNow("hitUnexpected", {outSSID, outHitInfo});
                else chk("hitWord", {outSSID, outHitInfo}, hitQ.pop_front());
            end
            if (ssidDone) begin
                doneSeen++;
                if (doneQ.size() == 0) failNow("doneUnexpected", ssidHitCount);
                else chk("doneCount", ssidHitCount, doneQ.pop_front());
            end
            prevHold = outValid && !outReady;
            prevOut  = {outSSID, outHitInfo};
        end
    end

    task automatic sendReq(input int ssid);
        int k;
        for (k = 0; k < 1000 && !reqReady; k++) @(posedge clock);
        if (!reqReady) failNow("reqReadyTimeout", k);
        reqValid = 1'b1;
        reqSSID  = 16'(ssid);
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        reqSSID  = 16'($urandom);
    endtask

    // One SSID readout: expectations from the list rules, then run it
    task automatic issue(input int ssid, input int len, input int lat);
        int target;
        int n;
        int k;
        bit timedOut;
        lenOf[ssid] = len;
        latency     = lat;
        timedOut    = (lat == 0) || (lat > TIMEOUT);
        target      = doneSeen + 1;
        if (timedOut) begin
            readQ.push_back({16'(ssid), 4'd0});
            doneQ.push_back(0);
            expErr = 1'b1;
        end else begin
            n = (len < MAXHITS) ? len : MAXHITS;
            for (int i = 0; i < n; i++) begin
                readQ.push_back({16'(ssid), 4'(i)});
                hitQ.push_back({16'(ssid), hitWord(ssid, i)});
            end
            if (len < MAXHITS) readQ.push_back({16'(ssid), 4'(len)});
            doneQ.push_back(n);
        end
        sendReq(ssid);
        for (k = 0; k < 5000 && doneSeen < target; k++) @(posedge clock);
        if (doneSeen < target) failNow("doneTimeout", doneSeen);
        #1;
        chk("readError", readError, expErr);
        chk("queuesDrained", readQ.size() + hitQ.size() + doneQ.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        reqValid = 1'b0;
        reqSSID  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rstReqReady", reqReady, 1);
        chk("rstMemRead", memRead, 0);
        chk("rstMemAddr", {memSSID, memIndex}, 0);
        chk("rstOut", {outValid, outSSID, outHitInfo}, 0);
        chk("rstDone", {ssidDone, ssidHitCount}, 0);
        chk("rstErr", readError, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three hits, latency 2, no backpressure
        issue(16'h0005, 3, 2);
        // Empty list
        issue(16'h0010, 0, 1);
        // Full list: more rows stored than are read
        issue(16'h0020, 20, 1);
        // Exactly MAXHITS rows
        issue(16'h0021, 16, 3);
        // Backpressure during the second hit
        fork
            issue(16'h0022, 3, 2);
            begin
                int base;
                base = acceptCnt;
                for (int k = 0; k < 500 && acceptCnt == base; k++) @(posedge clock);
                bpHold = 1'b1;
                repeat (8) @(posedge clock);
                bpHold = 1'b0;
            end
        join
        // Reply on the timeout edge wins
        issue(16'h0040, 1, TIMEOUT);
        // Storage silent
        issue(16'h0033, 2, 0);
        // Reply arrives after timeout, while idle
        issue(16'h0034, 2, 70);
        repeat (20) @(posedge clock);
        #1;
        chk("lateReplyIdle", {reqReady, memRead, outValid, ssidDone}, 4'b1000);
        // Next request normal, error still sticky
        issue(16'h0035, 2, 3);

        // Reset while waiting on storage
        lenOf[16'h0050] = 3;
        latency = 0;
        readQ.push_back({16'h0050, 4'd0});
        sendReq(16'h0050);
        repeat (10) @(posedge clock);
        chk("rstTestReadSeen", readQ.size(), 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("asyncReqReady", reqReady, 1);
        chk("asyncMemRead", memRead, 0);
        chk("asyncOutValid", outValid, 0);
        chk("asyncErr", readError, 0);
        readQ.delete();
        hitQ.delete();
        doneQ.delete();
        expErr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        acceptCnt = 0;
        issue(16'h0050, 3, 2);

        // Random traffic with random backpressure
        bpRandom = 1'b1;
        for (int r = 0; r < 25; r++) begin
            issue(int'($urandom_range(0, 65535)), int'($urandom_range(0, 20)),
                  int'($urandom_range(1, 6)));
        end
        bpRandom = 1'b0;
        repeat (4) @(posedge clock);

`ifdef HLM_READOUT_STATS_EN
        #1;
        chk("totalHits", totalHits, acceptCnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
